// File: rtl/otter_lsu_pkg.sv
// Shared types, size codes and helpers for the OTTER load/store unit data-port master.
package otter_lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      FINISH
   } lsuState_t;

   localparam logic [1:0]  SZ_BYTE           = 2'd0;
   localparam logic [1:0]  SZ_HALF           = 2'd1;
   localparam logic [1:0]  SZ_WORD           = 2'd2;
   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h11000000;

   // Size code 3 behaves as a word everywhere in the unit.
   function automatic logic [2:0] nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: nbytes = 3'd1;
         SZ_HALF: nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/otter_load_align.sv
// Combinational load assembly: picks nbytes starting at byte offset off out of {w1,w0}
// and zero- or sign-extends them (sign=1 means zero-extend, funct3[2] style).
module otter_load_align
   import otter_lsu_pkg::*;
(
   input  logic [31:0] i_w0,
   input  logic [31:0] i_w1,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   assign w_shifted = 32'({i_w1, i_w0} >> {i_off, 3'b000});

   always_comb begin
      o_data = w_shifted;
      case (i_size)
         SZ_BYTE: o_data = i_sign ? {24'h0, w_shifted[7:0]}
                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: o_data = i_sign ? {16'h0, w_shifted[15:0]}
                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/otter_lsu_mem_master.sv
// Load/store initiator for OTTER memory port 2: splits word-crossing loads into two
// aligned reads and crossing stores into byte writes; all outputs are registered.
module otter_lsu_mem_master
   import otter_lsu_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
   parameter bit          SPLIT_EN  = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LSU_REQ,
   input  logic        LSU_WE,
   input  logic [31:0] LSU_ADDR,
   input  logic [31:0] LSU_WDATA,
   input  logic [1:0]  LSU_SIZE,
   input  logic        LSU_SIGN,
   output logic        LSU_BUSY,
   output logic        LSU_DONE,
   output logic [31:0] LSU_RDATA,
   output logic        LSU_MISALIGN,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   lsuState_t   r_state;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic [1:0]  r_cnt;
   logic        r_sign;
   logic        r_cross;
   logic        r_mmio;
   logic        r_second;
   logic [31:0] r_w0;
   logic        r_busy;
   logic        r_done;
   logic        r_misalign;
   logic [31:0] r_rdata;
   logic [31:0] r_memAddr;
   logic [31:0] r_memDin;
   logic        r_memWrite;
   logic        r_memRead;
   logic [1:0]  r_memSize;
   logic        r_memSign;

   logic [2:0]  w_nbytes;
   logic        w_isMmio;
   logic        w_cross;
   logic [31:0] w_alW0;
   logic [31:0] w_alW1;
   logic [31:0] w_aligned;

   assign w_nbytes = nbytes(LSU_SIZE);
   assign w_isMmio = (LSU_ADDR >= MMIO_BASE);
   assign w_cross  = (({2'b00, LSU_ADDR[1:0]} + {1'b0, w_nbytes}) > 4'd4) && !w_isMmio;

   // Data arriving in the final RD_WAIT is the upper word of a split load, else the only word.
   assign w_alW0 = r_cross ? r_w0 : MEM_DOUT2;
   assign w_alW1 = r_cross ? MEM_DOUT2 : 32'h0;

   otter_load_align u_align (
      .i_w0   (w_alW0),
      .i_w1   (w_alW1),
      .i_off  (r_off),
      .i_size (r_size),
      .i_sign (r_sign),
      .o_data (w_aligned)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_off      <= 2'd0;
         r_size     <= 2'd0;
         r_cnt      <= 2'd0;
         r_sign     <= 1'b0;
         r_cross    <= 1'b0;
         r_mmio     <= 1'b0;
         r_second   <= 1'b0;
         r_w0       <= 32'h0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_rdata    <= 32'h0;
         r_memAddr  <= 32'h0;
         r_memDin   <= 32'h0;
         r_memWrite <= 1'b0;
         r_memRead  <= 1'b0;
         r_memSize  <= 2'd0;
         r_memSign  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (LSU_REQ) begin
                  r_off      <= LSU_ADDR[1:0];
                  r_size     <= LSU_SIZE;
                  r_sign     <= LSU_SIGN;
                  r_cross    <= w_cross;
                  r_mmio     <= w_isMmio;
                  r_second   <= 1'b0;
                  r_cnt      <= 2'd0;
                  r_busy     <= 1'b1;
                  r_misalign <= w_cross;
                  if (w_cross && !SPLIT_EN) begin
                     r_state <= FINISH;
                     r_done  <= 1'b1;
                  end else if (LSU_WE) begin
                     r_state    <= WR_ISSUE;
                     r_memWrite <= 1'b1;
                     r_memAddr  <= LSU_ADDR;
                     r_memDin   <= LSU_WDATA;
                     r_memSize  <= w_cross ? SZ_BYTE : LSU_SIZE;
                     r_memSign  <= LSU_SIGN;
                  end else begin
                     r_state   <= RD_ISSUE;
                     r_memRead <= 1'b1;
                     r_memAddr <= w_isMmio ? LSU_ADDR : {LSU_ADDR[31:2], 2'b00};
                     r_memSize <= SZ_WORD;
                     r_memSign <= 1'b0;
                  end
               end
            end
            RD_ISSUE: begin
               r_memRead <= 1'b0;
               r_state   <= RD_WAIT;
            end
            RD_WAIT: begin
               if (r_cross && !r_second) begin
                  r_w0      <= MEM_DOUT2;
                  r_second  <= 1'b1;
                  r_memAddr <= r_memAddr + 32'd4;
                  r_memRead <= 1'b1;
                  r_state   <= RD_ISSUE;
               end else begin
                  r_rdata <= r_mmio ? MEM_DOUT2 : w_aligned;
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end
            end
            WR_ISSUE: begin
               if (!r_cross || ({1'b0, r_cnt} == (nbytes(r_size) - 3'd1))) begin
                  r_memWrite <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= FINISH;
               end else begin
                  // Next byte of a crossing store: the low DIN byte always carries the data.
                  r_cnt     <= r_cnt + 2'd1;
                  r_memAddr <= r_memAddr + 32'd1;
                  r_memDin  <= r_memDin >> 8;
               end
            end
            FINISH: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign LSU_BUSY     = r_busy;
   assign LSU_DONE     = r_done;
   assign LSU_RDATA    = r_rdata;
   assign LSU_MISALIGN = r_misalign;
   assign MEM_ADDR2    = r_memAddr;
   assign MEM_DIN2     = r_memDin;
   assign MEM_WRITE2   = r_memWrite;
   assign MEM_READ2    = r_memRead;
   assign MEM_SIZE     = r_memSize;
   assign MEM_SIGN     = r_memSign;

endmodule

// File: doc/otter_lsu_mem_master.md
Name: otter_lsu_mem_master

Overview:
- Load/store initiator for the data port (port 2) of the OTTER dual-port memory. It sits between the CPU memory stage and the memory.
- Accepts one byte, half or word request at a time, sign- or zero-extends load data, and returns a completion pulse.
- Owns the port-2 strobes, which have 1-cycle registered read latency.
- Supports word-crossing accesses that the memory cannot do in one access:
  - crossing loads are split into two aligned word reads;
  - crossing stores become a sequence of byte stores.

Parameters:
- MMIO_BASE, 32'h11000000: addresses >= this are MMIO. MMIO accesses are always single, never split.
- SPLIT_EN, 1: 1 = split crossing accesses; 0 = reject them with the misalign flag and issue no memory strobe.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- LSU_REQ  in  1  request valid. Sampled only when LSU_BUSY=0.
- LSU_WE  in  1  1 = store, 0 = load.
- LSU_ADDR  in  32  byte address.
- LSU_WDATA  in  32  store data, right-aligned.
- LSU_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- LSU_SIGN  in  1  funct3[2] convention: 1 = zero-extend, 0 = sign-extend.
- LSU_BUSY  out  1  high from the cycle after accept until the DONE cycle inclusive.
- LSU_DONE  out  1  1-cycle completion pulse.
- LSU_RDATA  out  32  load result. Valid with DONE and held until the next accept.
- LSU_MISALIGN  out  1  valid with DONE; 1 = access crossed a word boundary.
- MEM_ADDR2  out  32  registered data-port address.
- MEM_DIN2  out  32  registered store data.
- MEM_WRITE2  out  1  write strobe.
- MEM_READ2  out  1  read strobe.
- MEM_SIZE  out  2  size driven to memory.
- MEM_SIGN  out  1  sign control driven to memory. Always 0 on reads.
- MEM_DOUT2  in  32  read data. Valid the cycle after MEM_READ2.

Behaviour:
- Reset (synchronous): RST=1 forces state IDLE. All outputs are 0, including LSU_RDATA. Asserted mid-operation, it aborts: no strobe in the following cycle and no DONE pulse.
- Accept: IDLE and LSU_REQ in cycle 0 latches all request fields. off = ADDR[1:0], nbytes = 1/2/4.
- Crossing test: crossing = (off + nbytes > 4) and address < MMIO_BASE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, FINISH.
- Non-MMIO load:
  - RD_ISSUE drives MEM_READ2=1, MEM_ADDR2 = {ADDR[31:2],2'b00}, MEM_SIZE=2, MEM_SIGN=0.
  - RD_WAIT holds address, size and sign stable, de-asserts READ2, and captures MEM_DOUT2 into w0.
  - If crossing, RD_ISSUE/RD_WAIT repeat at word address + 4, capturing w1.
  - Then FINISH.
- Load assembly: result = ({w1,w0} >> 8*off), truncated to nbytes, then extended per LSU_SIGN.
- MMIO load: a single read at the original address with MEM_SIZE=2. The raw MEM_DOUT2 is returned; no extension.
- Non-crossing store (RAM or MMIO): one WR_ISSUE cycle with MEM_WRITE2=1, original address, LSU_SIZE, and WDATA.
- Crossing store: nbytes WR_ISSUE cycles in ascending address order. Cycle k drives address ADDR+k, MEM_SIZE=0, MEM_DIN2 = WDATA >> 8k. A byte counter selects the byte.
- FINISH: LSU_DONE=1, LSU_BUSY=1, then IDLE. LSU_REQ is ignored in FINISH; a back-to-back accept is possible in the following IDLE cycle.
- Latency (DONE cycle after accept at cycle 0):
  - aligned load: 3
  - crossing load: 5
  - aligned store: 2
  - crossing store: nbytes + 1
  - rejected access (SPLIT_EN=0): 1
- LSU_REQ while busy is ignored, not queued.
- Strobes: MEM_READ2 and MEM_WRITE2 are never high together and are never high outside the ISSUE states.
- Address wrap: wrap at 32'hFFFFFFFF is modulo 2^32.

Decomposition:
- Package otter_lsu_pkg holds:
  - the state enum;
  - SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - the default MMIO_BASE;
  - an nbytes(size) function.
- Sub-module otter_load_align is combinational: w0, w1, off, size, sign in; aligned/extended word out.

Test Plan:
Memory preloaded with 0x100 = 0x44332211 and 0x104 = 0x88776655.
- Aligned load: lw 0x100 at c0 -> READ2 at c1 (addr 0x100, size 2, sign 0); DONE c3; RDATA = 0x44332211; MISALIGN = 0.
- Crossing load: lw 0x102 -> reads 0x100 (c1) and 0x104 (c3); DONE c5; RDATA = 0x66554433; MISALIGN = 1.
- Byte load extension: lb 0x107 -> 0xFFFFFF88; lbu 0x107 -> 0x00000088.
- Crossing store: sw 0x106 with data 0xAABBCCDD -> byte writes c1..c4 to 0x106/7/8/9 with DIN low byte DD, CC, BB, AA; DONE c5. Readback: lw 0x104 -> 0xCCDD6655; lhu 0x108 -> 0x0000AABB.
- MMIO: sw 0x11000040 with data 5 -> single WRITE2 at c1 (size 2); DONE c2. lw 0x11000000 with IO_IN = 0x1234 -> RDATA = 0x00001234, no split.
- Reset and reject: RST at c3 of a crossing store -> no WRITE2 from c4, BUSY = 0 at c4, no DONE. SPLIT_EN = 0 with lh 0x103 -> DONE c1, MISALIGN = 1, no strobes.
